ps2_scancode_decoder: RTL
=========================

# ps2_scancode_decoder

Consumes completed PS/2 frames from the PS/2 interface state controller and shift register, and turns Set-2 scan-code byte sequences into single key events. It recognises the `E0` (extended) and `F0` (break) prefixes and discards keyboard response bytes. Decoded events are buffered in a small FIFO and offered downstream on a valid/ready handshake. It sits between the PS/2 receive path, once that path has been synchronised into the system clock domain, and the keyboard consumer (CPU-visible register or key-state logic).

## Interface
- `FIFO_DEPTH`, 4, number of event entries; must be a power of 2, at least 2.
- `clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  reset. One clock; reset is synchronous and active-low.
- `frame_strobe`  in  1  one-cycle pulse: a frame completed. May assert on consecutive cycles.
- `frame_byte`  in  8  received data byte; sampled only when `frame_strobe`=1.
- `frame_ok`  in  1  stop bit and parity were valid; sampled only when `frame_strobe`=1.
- `ev_valid`  out  1  FIFO non-empty; the head event is presented.
- `ev_ready`  in  1  consumer accepts the head event.
- `ev_code`  out  8  scan code of the head event (prefixes stripped).
- `ev_extended`  out  1  1 if the event was `E0`-prefixed.
- `ev_release`  out  1  1 if the event was a break (`F0`-prefixed).
- `err_count`  out  8  saturating count of protocol and frame errors.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.

## Operation
- The decoder FSM has four states: IDLE, GOT_E0, GOT_F0, GOT_E0F0. It advances only on cycles where `frame_strobe`=1.
- `frame_ok`=0, in any state:
  - `err_count` increments.
  - The FSM goes to IDLE.
  - No event is pushed.
- Response bytes `00`, `AA`, `EE`, `FA`, `FE`, `FF` with `frame_ok`=1, in any state:
  - The byte is discarded.
  - The FSM goes to IDLE.
  - No error is counted.
- IDLE:
  - `E0` goes to GOT_E0.
  - `F0` goes to GOT_F0.
  - Any other byte pushes {ext=0, rel=0, code}.
- GOT_E0:
  - `F0` goes to GOT_E0F0.
  - `E0` stays in GOT_E0, with no error.
  - Any other byte pushes {1, 0, code} and goes to IDLE.
- GOT_F0:
  - `E0` or `F0` increments `err_count` and goes to IDLE.
  - Any other byte pushes {0, 1, code} and goes to IDLE.
- GOT_E0F0:
  - `E0` or `F0` increments `err_count` and goes to IDLE.
  - Any other byte pushes {1, 1, code} and goes to IDLE.
- The FIFO holds 10-bit entries {ext, rel, code[7:0]} and has show-ahead output.
  - Read and write pointers are log2(FIFO_DEPTH) bits wide and wrap modulo depth.
  - The occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- Pop happens when `ev_valid` && `ev_ready`. `ev_ready` is ignored when the FIFO is empty.
- Push when full, with no pop in the same cycle:
  - The event is dropped.
  - `overflow` is set to 1.
  - FIFO contents are unchanged.
- Push when full, with a pop in the same cycle: the push is accepted, `overflow` is not set, and occupancy stays at FIFO_DEPTH.
- Push and pop in the same cycle at any other occupancy: occupancy is unchanged.
- `err_count` saturates at 255.
- `overflow` is cleared only by reset.
- `ev_code`, `ev_extended` and `ev_release` are forced to 0 while `ev_valid`=0.

## Timing
- Reset, with `reset_n` sampled low at posedge:
  - FSM goes to IDLE.
  - FIFO is emptied (pointers 0, count 0).
  - `ev_valid`=0; `ev_code`=0, `ev_extended`=0, `ev_release`=0.
  - `err_count`=0, `overflow`=0.
  - Reset overrides any concurrent strobe or pop.
- A reset mid-sequence (e.g. in GOT_E0F0) discards the pending prefix. The next byte is decoded from IDLE.
- Latency: a final byte strobed at edge N causes `ev_valid`=1 and correct event fields after edge N, i.e. in cycle N+1.
- Pop handshake: the head is consumed at the edge where `ev_valid`&&`ev_ready`=1. The next entry, or `ev_valid`=0, is visible in the following cycle.
- `err_count` and `overflow` update at the same edge as the triggering strobe.
- All outputs are registered or derived from registers only. There are no combinational paths from inputs to outputs.

## Test plan
- Make code: strobe `1C` with ok=1 and `ev_ready`=0.
  - Expect `ev_valid`=1, ev={0,0,1C} one cycle later.
  - Raise `ev_ready` for one cycle; expect `ev_valid`=0 next cycle.
- Prefix decoding: strobe `F0 1C`, then `E0 75`, then `E0 F0 75`, back-to-back, with `ev_ready`=1.
  - Expect three events in order: {0,1,1C}, {1,0,75}, {1,1,75}.
  - Expect `err_count`=0.
- Errors:
  - Strobe `E0`, then `3A` with ok=0: expect `err_count`=1 and no event.
  - Then strobe `1C` ok=1: expect event {0,0,1C}.
  - Then strobe `F0 F0`: expect `err_count`=2.
- Discards: strobe `AA`, `FA`, and `E0 FE 1C`. Expect exactly one event, {0,0,1C}, with `err_count` unchanged.
- Overflow, with depth 4 and `ev_ready`=0:
  - Strobe `11 12 13 14 15`: expect `overflow`=1 and the FIFO popping 11, 12, 13, 14 in order.
  - Then, with the FIFO full, strobe `16` in the same cycle as a pop: expect the push accepted, occupancy still 4, and `16` appearing last.
- Reset mid-operation: with 2 events queued and FSM in GOT_E0F0, pulse `reset_n` low for one cycle.
  - Expect all outputs at reset values.
  - A following strobe of `1C` yields {0,0,1C}.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// Set-2 PS/2 scan-code decoder: folds E0/F0 prefixes into single key events,
// drops keyboard response bytes, and queues events in a show-ahead FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_strobe,
  input  logic [7:0] frame_byte,
  input  logic       frame_ok,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_extended,
  output logic       ev_release,
  output logic [7:0] err_count,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;

  state_t      state, state_nxt;
  logic        push, err_inc;
  logic [9:0]  push_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, wr_en;

  function automatic logic is_response(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_inc   = 1'b0;
    push_data = {2'b00, frame_byte};
    if (frame_strobe) begin
      if (!frame_ok) begin
        err_inc   = 1'b1;
        state_nxt = IDLE;
      end else if (is_response(frame_byte)) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (frame_byte == 8'hE0)      state_nxt = GOT_E0;
            else if (frame_byte == 8'hF0) state_nxt = GOT_F0;
            else                          push = 1'b1;
          end
          GOT_E0: begin
            if (frame_byte == 8'hF0) begin
              state_nxt = GOT_E0F0;
            end else if (frame_byte != 8'hE0) begin
              push      = 1'b1;
              push_data = {2'b10, frame_byte};
              state_nxt = IDLE;
            end
          end
          GOT_F0, GOT_E0F0: begin
            state_nxt = IDLE;
            if (frame_byte == 8'hE0 || frame_byte == 8'hF0) begin
              err_inc = 1'b1;
            end else begin
              push      = 1'b1;
              push_data = {(state == GOT_E0F0), 1'b1, frame_byte};
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  assign empty = (count == '0);
  assign full  = (count == DEPTH_CNT);
  assign pop   = !empty && ev_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  // NOTE: state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 1'b1;
      if (push && full && !pop)          overflow  <= 1'b1;
    end
  end

  // NOTE: storage has no reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign ev_valid = !empty;
  assign {ev_extended, ev_release, ev_code} = empty ? 10'd0 : mem[rd_ptr];

endmodule
